// File: rtl/zero_heap_pkg.sv
// Shared types for the zero VM heap engine: opcodes, FSM states and
// the registered response record.
package zero_heap_pkg;

    localparam int unsigned RSP_W = 32;

    typedef enum logic [2:0] {
        OP_ALLOC = 3'd0,
        OP_FREE  = 3'd1,
        OP_WRITE = 3'd2,
        OP_READ  = 3'd3,
        OP_SIZE  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RESP
    } state_t;

    // data is sized for the widest supported element; users take the low bits
    typedef struct packed {
        logic [RSP_W-1:0] data;
        logic             error;
    } rsp_t;

endpackage

// File: rtl/heap_array_store_if.sv
// Command/response channel of the heap engine.
// The master issues commands and consumes responses.
interface heap_array_store_if #(
    parameter int unsigned WIDTH = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_array;
    logic [WIDTH-1:0] cmd_index;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/zero_free_stack.sv
// LIFO of freed array ids; only live ids are pushed, so DEPTH
// entries always suffice.
module zero_free_stack #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned IW    = 1
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [IW-1:0] push_id,
    output logic [IW-1:0] top_id,
    output logic          empty
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] count;
    logic [CW-1:0] top_ptr;
    logic [IW-1:0] mem [DEPTH];

    assign empty   = (count == '0);
    assign top_ptr = count - 1'b1;
    assign top_id  = empty ? '0 : mem[top_ptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (push) begin
            mem[count[PW-1:0]] <= push_id;
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/heap_array_store.sv
// Heap and array-allocation engine: one command at a time,
// response registered one cycle after accept.
module heap_array_store
    import zero_heap_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned N_AREA   = 3,
    parameter int unsigned N_ARRAYS = 1
) (
    input  logic             clock,
    input  logic             reset,
    heap_array_store_if.slave bus,
    output logic [WIDTH-1:0] allocs
);
    localparam int unsigned DEPTH = N_ARRAYS * N_AREA;
    localparam int unsigned HAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW    = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1;

    state_t state_q, state_d;
    logic [IW-1:0] init_q;
    logic [N_ARRAYS-1:0] live_q;
    logic [WIDTH-1:0] size_q [N_ARRAYS];
    logic [WIDTH-1:0] heap [DEPTH];
    rsp_t rsp_q, rsp_d;

    logic fire, id_ok, is_live, st_empty;
    logic [IW-1:0] id, st_top, alloc_id, tbl_id;
    logic [WIDTH-1:0] cur_size, new_size, size_wd;
    logic [HAW-1:0] addr;
    logic live_set, live_clr, size_we, heap_we;
    logic push, pop, bump;

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_q.data[WIDTH-1:0];
    assign bus.rsp_error = rsp_q.error;

    generate
        if (WIDTH < RSP_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^rsp_q.data[RSP_W-1:WIDTH];
        end
    endgenerate

    assign fire     = (state_q == IDLE) && bus.cmd_valid && !reset;
    assign id       = bus.cmd_array[IW-1:0];
    assign id_ok    = bus.cmd_array < WIDTH'(N_ARRAYS);
    assign is_live  = id_ok && live_q[id];
    assign cur_size = size_q[id];
    assign new_size = (bus.cmd_index >= cur_size) ?
                      bus.cmd_index + WIDTH'(1) : cur_size;
    // Only used after the range checks pass, so it never wraps
    assign addr     = HAW'(id) * HAW'(N_AREA) + HAW'(bus.cmd_index);
    assign alloc_id = st_empty ? allocs[IW-1:0] : st_top;

    zero_free_stack #(.DEPTH(N_ARRAYS), .IW(IW)) u_stack (
        .clock   (clock),
        .clear   (reset),
        .push    (fire && push),
        .pop     (fire && pop),
        .push_id (id),
        .top_id  (st_top),
        .empty   (st_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_q == IW'(N_ARRAYS - 1)) state_d = IDLE;
            IDLE:    if (fire) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        rsp_d    = '{data: '0, error: 1'b1};
        tbl_id   = id;
        live_set = 1'b0;
        live_clr = 1'b0;
        size_we  = 1'b0;
        size_wd  = '0;
        heap_we  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        bump     = 1'b0;
        case (op_t'(bus.cmd_op))
            OP_ALLOC: begin
                if (!st_empty || allocs < WIDTH'(N_ARRAYS)) begin
                    pop      = !st_empty;
                    bump     = st_empty;
                    tbl_id   = alloc_id;
                    live_set = 1'b1;
                    size_we  = 1'b1;
                    rsp_d    = '{data: RSP_W'(alloc_id), error: 1'b0};
                end
            end
            OP_FREE: begin
                if (is_live) begin
                    live_clr = 1'b1;
                    push     = 1'b1;
                    rsp_d    = '{data: RSP_W'(bus.cmd_array), error: 1'b0};
                end
            end
            OP_WRITE: begin
                if (is_live && bus.cmd_index < WIDTH'(N_AREA)) begin
                    heap_we = 1'b1;
                    size_we = 1'b1;
                    size_wd = new_size;
                    rsp_d   = '{data: RSP_W'(new_size), error: 1'b0};
                end
            end
            OP_READ: begin
                if (is_live && bus.cmd_index < cur_size)
                    rsp_d = '{data: RSP_W'(heap[addr]), error: 1'b0};
            end
            OP_SIZE: begin
                if (is_live)
                    rsp_d = '{data: RSP_W'(cur_size), error: 1'b0};
            end
            default: rsp_d = '{data: '0, error: 1'b1};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            init_q  <= '0;
            rsp_q   <= '0;
            allocs  <= '0;
            live_q  <= '0;
            for (int i = 0; i < N_ARRAYS; i++) size_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_q         <= init_q + 1'b1;
                live_q[init_q] <= 1'b0;
                size_q[init_q] <= '0;
            end
            if (fire) begin
                rsp_q <= rsp_d;
                if (live_set) live_q[tbl_id] <= 1'b1;
                if (live_clr) live_q[tbl_id] <= 1'b0;
                if (size_we)  size_q[tbl_id] <= size_wd;
                if (bump)     allocs <= allocs + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fire && heap_we) heap[addr] <= bus.cmd_data;
    end
endmodule

// File: tb/tb_heap_array_store.sv
// Bench for heap_array_store: directed table, hold/reset sequences
// and random commands against a queue-based reference model.
module tb_heap_array_store;
    localparam int NA = 2;
    localparam int AREA = 3;
    localparam int W = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] allocs;
    int total = 0;
    int passed = 0;

    heap_array_store_if #(.WIDTH(W)) bus ();

    heap_array_store #(.WIDTH(W), .N_AREA(AREA), .N_ARRAYS(NA)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .allocs (allocs)
    );

    always #5 clock = ~clock;

    bit live_m [NA];
    int size_m [NA];
    int heap_m [NA*AREA];
    int stack_m [$];
    int allocs_m;

    typedef struct {
        logic [2:0] op;
        int a, i, d;
        int ed;
        bit ee;
    } vec_t;
    vec_t tbl [22];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NA; k++) begin
            live_m[k] = 0;
            size_m[k] = 0;
        end
        stack_m.delete();
        allocs_m = 0;
    endtask

    task automatic model(input int op, input int a, input int i,
                         input int d, output int ed, output bit ee);
        bit lv;
        ed = 0;
        ee = 1;
        lv = (a < NA) ? live_m[a] : 0;
        case (op)
            0: begin
                int nid = -1;
                if (stack_m.size() > 0) nid = stack_m.pop_back();
                else if (allocs_m < NA) begin
                    nid = allocs_m;
                    allocs_m++;
                end
                if (nid >= 0) begin
                    live_m[nid] = 1;
                    size_m[nid] = 0;
                    ed = nid;
                    ee = 0;
                end
            end
            1: if (lv) begin
                live_m[a] = 0;
                stack_m.push_back(a);
                ed = a;
                ee = 0;
            end
            2: if (lv && i < AREA) begin
                heap_m[a*AREA+i] = d;
                if (i + 1 > size_m[a]) size_m[a] = i + 1;
                ed = size_m[a];
                ee = 0;
            end
            3: if (lv && i < size_m[a]) begin
                ed = heap_m[a*AREA+i];
                ee = 0;
            end
            4: if (lv) begin
                ed = size_m[a];
                ee = 0;
            end
            default: ;
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 0, 1);
    endtask

    // Issue one command from a negedge; returns the response at the
    // first negedge after accept and leaves at a negedge in IDLE.
    task automatic issue(input int op, input int a, input int i,
                         input int d, input int stall,
                         output int rd, output bit re);
        int n = 0;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_array = W'(a);
        bus.cmd_index = W'(i);
        bus.cmd_data  = W'(d);
        bus.rsp_ready = (stall == 0);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_array = W'($urandom);
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.rsp_valid) chk("rsp_valid_timeout", 0, 1);
        rd = int'(bus.rsp_data);
        re = bus.rsp_error;
        repeat (stall) @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int rd, ed;
        bit re, ee;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_array = '0;
        bus.cmd_index = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        tbl = '{
            '{3'd4, 0, 0, 0,  0, 1'b1},
            '{3'd0, 0, 0, 0,  0, 1'b0},
            '{3'd2, 0, 0, 10, 1, 1'b0},
            '{3'd2, 0, 1, 20, 2, 1'b0},
            '{3'd2, 0, 2, 30, 3, 1'b0},
            '{3'd3, 0, 1, 0,  20, 1'b0},
            '{3'd4, 0, 0, 0,  3, 1'b0},
            '{3'd0, 0, 0, 0,  1, 1'b0},
            '{3'd0, 0, 0, 0,  0, 1'b1},
            '{3'd1, 1, 0, 0,  1, 1'b0},
            '{3'd1, 1, 0, 0,  0, 1'b1},
            '{3'd0, 0, 0, 0,  1, 1'b0},
            '{3'd4, 1, 0, 0,  0, 1'b0},
            '{3'd2, 0, 3, 99, 0, 1'b1},
            '{3'd2, 1, 0, 5,  1, 1'b0},
            '{3'd3, 1, 2, 0,  0, 1'b1},
            '{3'd6, 0, 0, 0,  0, 1'b1},
            '{3'd3, 0, 2, 0,  30, 1'b0},
            '{3'd4, 1, 0, 0,  1, 1'b0},
            '{3'd1, 5, 0, 0,  0, 1'b1},
            '{3'd7, 0, 0, 0,  0, 1'b1},
            '{3'd4, 0, 0, 0,  3, 1'b0}
        };

        do_reset();
        chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_rsp_error", int'(bus.rsp_error), 0);
        chk("rst_allocs", int'(allocs), 0);
        @(negedge clock);
        chk("init_ready_c1", int'(bus.cmd_ready), 0);
        @(negedge clock);
        chk("init_ready_c2", int'(bus.cmd_ready), 1);

        for (int k = 0; k < 22; k++) begin
            model(int'(tbl[k].op), tbl[k].a, tbl[k].i, tbl[k].d, ed, ee);
            issue(int'(tbl[k].op), tbl[k].a, tbl[k].i, tbl[k].d, 0, rd, re);
            chk($sformatf("vec%0d_data", k), rd, tbl[k].ed);
            chk($sformatf("vec%0d_err", k), int'(re), int'(tbl[k].ee));
        end
        chk("allocs_hwm", int'(allocs), 2);

        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_array = '0;
        bus.cmd_index = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", int'(bus.rsp_valid), 1);
            chk("hold_data", int'(bus.rsp_data), 10);
            chk("hold_error", int'(bus.rsp_error), 0);
            chk("hold_cmd_ready", int'(bus.cmd_ready), 0);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'd1;
            @(negedge clock);
            bus.cmd_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk("hold_release", int'(bus.rsp_valid), 0);
        issue(4, 1, 0, 0, 0, rd, re);
        chk("hold_nochange", rd, 1);

        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        bus.cmd_array = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        chk("pre_rst_valid", int'(bus.rsp_valid), 1);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk("midrst_valid", int'(bus.rsp_valid), 0);
        chk("midrst_ready", int'(bus.cmd_ready), 0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk("midrst_init", int'(bus.cmd_ready), 0);
        @(negedge clock);
        chk("midrst_idle", int'(bus.cmd_ready), 1);
        chk("midrst_allocs", int'(allocs), 0);
        issue(4, 0, 0, 0, 0, rd, re);
        chk("midrst_size_err", int'(re), 1);
        chk("midrst_size_data", rd, 0);

        for (int k = 0; k < 300; k++) begin
            int sel, op, a, i, d, st;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    op = 0;
                2, 9:    op = 1;
                3, 4:    op = 2;
                5, 6:    op = 3;
                7:       op = 4;
                default: op = $urandom_range(5, 7);
            endcase
            a  = $urandom_range(0, 2);
            i  = $urandom_range(0, 3);
            d  = $urandom_range(0, 4095);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            model(op, a, i, d, ed, ee);
            issue(op, a, i, d, st, rd, re);
            chk($sformatf("rnd%0d_op%0d_data", k, op), rd, ed);
            chk($sformatf("rnd%0d_op%0d_err", k, op), int'(re), int'(ee));
        end
        chk("rnd_allocs", int'(allocs), allocs_m);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
